// File: rtl/run_seq_pkg.sv
// Shared constants for the run sequencer: default parameters and FSM state codes.
package run_seq_pkg;

    localparam int DEF_AW       = 8;
    localparam int DEF_LOAD_LEN = 64;
    localparam int DEF_RD_BASE  = 64;
    localparam int DEF_RD_LEN   = 32;
    localparam int DEF_TIMEOUT  = 4095;

    typedef logic [2:0] state_t;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_START    = 3'd2;
    localparam logic [2:0] S_RUN      = 3'd3;
    localparam logic [2:0] S_RD_FETCH = 3'd4;
    localparam logic [2:0] S_RD_SEND  = 3'd5;
    localparam logic [2:0] S_ERR      = 3'd6;

endpackage

// File: rtl/run_seq_timer.sv
// Clearable, saturating run-cycle counter. reached_o flags the counting cycle
// on which the count arrives at TIMEOUT, so the caller can abort in that cycle.
module run_seq_timer
    import run_seq_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic reached_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear wins over count; the count stops at TIMEOUT instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CW'(TIMEOUT))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign reached_o = en_i && !clr_i && (cnt_q >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/run_sequencer.sv
// Load / run / readback sequencer: streams LOAD_LEN bytes into data memory,
// kicks the core, waits for a fresh done, then streams RD_LEN bytes back out.
// Handshakes: a byte moves on a cycle where valid && ready are both high;
// valid/data are held until that cycle, and ready never depends on valid.
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int LOAD_LEN = DEF_LOAD_LEN,
    parameter int RD_BASE  = DEF_RD_BASE,
    parameter int RD_LEN   = DEF_RD_LEN,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          core_req,
    input  logic          core_done,
    output logic          dm_wr_en,
    output logic [AW-1:0] dm_addr,
    output logic [7:0]    dm_wdat,
    input  logic [7:0]    dm_rdat,
    output logic          out_valid,
    output logic [7:0]    out_data,
    input  logic          out_ready,
    output logic          busy,
    output logic          seq_done,
    output logic          err,
    output logic [2:0]    state_o
);

    localparam int RCW = $clog2(RD_LEN + 1);

    state_t         state_q, state_d;
    logic [AW-1:0]  ptr_q, ptr_d;
    logic [RCW-1:0] rd_cnt_q, rd_cnt_d;
    logic           arm_q, arm_d;
    logic           err_q, err_d;
    logic [7:0]     out_data_q, out_data_d;
    logic           timeout_hit;
    logic           rd_last;

    run_seq_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (state_q == S_START),
        .en_i      (state_q == S_RUN),
        .reached_o (timeout_hit)
    );

    assign rd_last   = (rd_cnt_q == RCW'(RD_LEN - 1));
    assign in_ready  = (state_q == S_LOAD);
    assign dm_wr_en  = in_ready && in_valid;
    assign dm_wdat   = dm_wr_en ? in_data : 8'h00;
    assign dm_addr   = ptr_q;
    assign core_req  = (state_q == S_START);
    assign out_valid = (state_q == S_RD_SEND);
    assign out_data  = out_data_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_ERR);
    assign seq_done  = out_valid && out_ready && rd_last;
    assign err       = err_q;
    assign state_o   = state_q;

    // Next-state and datapath decisions for the whole sequence.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rd_cnt_d   = rd_cnt_q;
        arm_d      = arm_q;
        err_d      = err_q;
        out_data_d = out_data_q;
        case (state_q)
            S_IDLE, S_ERR: begin
                if (start) begin
                    state_d = S_LOAD;
                    ptr_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    ptr_d = ptr_q + AW'(1);
                    if (ptr_q == AW'(LOAD_LEN - 1)) begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                state_d = S_RUN;
                arm_d   = 1'b0;
            end
            S_RUN: begin
                // A done level left over from the previous run must first drop.
                if (!core_done) begin
                    arm_d = 1'b1;
                end
                if (arm_q && core_done) begin
                    state_d  = S_RD_FETCH;
                    ptr_d    = AW'(RD_BASE);
                    rd_cnt_d = '0;
                end else if (timeout_hit) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end
            end
            S_RD_FETCH: begin
                out_data_d = dm_rdat;
                state_d    = S_RD_SEND;
            end
            S_RD_SEND: begin
                if (out_ready) begin
                    if (rd_last) begin
                        state_d = S_IDLE;
                    end else begin
                        ptr_d    = ptr_q + AW'(1);
                        rd_cnt_d = rd_cnt_q + RCW'(1);
                        state_d  = S_RD_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any sequence in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            rd_cnt_q   <= '0;
            arm_q      <= 1'b0;
            err_q      <= 1'b0;
            out_data_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rd_cnt_q   <= rd_cnt_d;
            arm_q      <= arm_d;
            err_q      <= err_d;
            out_data_q <= out_data_d;
        end
    end

endmodule

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 Parameter AW, default 8: data-memory address width.
REQ-002 Parameter LOAD_LEN, default 64: bytes written to data memory per run, starting at address 0.
REQ-003 Parameter RD_BASE, default 64: first data-memory address read back after a run.
REQ-004 Parameter RD_LEN, default 32: bytes read back per run.
REQ-005 Parameter TIMEOUT, default 4095: maximum RUN cycles before abort.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-low; 0 = reset asserted.
REQ-008 start  in  1  one-cycle request to begin a load/run/readback sequence.
REQ-009 in_valid  in  1  load byte valid.
REQ-010 in_data  in  8  load byte.
REQ-011 in_ready  out  1  load byte accepted when in_valid && in_ready.
REQ-012 core_req  out  1  one-cycle start pulse to the processor core.
REQ-013 core_done  in  1  processor done level.
REQ-014 dm_wr_en  out  1  data-memory write enable.
REQ-015 dm_addr  out  AW  data-memory address.
REQ-016 dm_wdat  out  8  data-memory write data.
REQ-017 dm_rdat  in  8  data-memory read data, combinational from dm_addr.
REQ-018 out_valid  out  1  readback byte valid.
REQ-019 out_data  out  8  readback byte, registered.
REQ-020 out_ready  in  1  readback byte consumed when out_valid && out_ready.
REQ-021 busy  out  1  high in every state except IDLE and ERR.
REQ-022 seq_done  out  1  one-cycle pulse when the last readback byte is consumed.
REQ-023 err  out  1  sticky timeout flag.

Function
REQ-024 FSM states SHALL be IDLE, LOAD, START, RUN, RD_FETCH, RD_SEND and ERR.
REQ-025 IDLE/ERR: start -> LOAD; ptr=0; err cleared. start SHALL be ignored in every other state.
REQ-026 LOAD: in_ready=1; on each accepted byte, dm_wr_en=1, dm_addr=ptr, dm_wdat=in_data, ptr++; no write when in_valid=0.
REQ-027 LOAD: acceptance of byte LOAD_LEN-1 -> START next cycle; in_ready=0 in all other states.
REQ-028 START: core_req=1 for exactly one cycle -> RUN; clear the timeout counter and the arm flag.
REQ-029 RUN: arm flag sets on the first cycle core_done=0; core_done=1 SHALL complete the run only when armed, so a stale done level from the previous run is ignored.
REQ-030 RUN: armed && core_done -> RD_FETCH; ptr=RD_BASE.
REQ-031 RUN: timeout counter increments every RUN cycle; reaching TIMEOUT without completion -> ERR; err=1.
REQ-032 If completion and timeout occur in the same cycle, completion SHALL win.
REQ-033 RD_FETCH: dm_addr=ptr; out_data <= dm_rdat -> RD_SEND.
REQ-034 RD_SEND: out_valid=1 and out_data held stable until out_ready.
REQ-035 RD_SEND handshake: ptr++ -> RD_FETCH; on the RD_LEN-th byte -> IDLE with seq_done=1 instead.
REQ-036 ptr SHALL be AW bits and wrap modulo 2^AW; RD_BASE+RD_LEN beyond 2^AW wraps to address 0.
REQ-037 dm_wr_en SHALL be 0 outside LOAD; dm_addr=ptr in all states.

Reset
REQ-038 reset=0 SHALL immediately force IDLE, ptr=0, counters=0, arm=0, err=0, out_data=0, and all handshake/pulse outputs 0.
REQ-039 Reset mid-sequence SHALL abandon the sequence without issuing any further core_req or dm write.

Structure
REQ-040 Package run_seq_pkg SHALL hold the state enum and the default parameter constants.
REQ-041 Sub-module run_seq_timer SHALL implement the clearable, saturating timeout counter with a TIMEOUT-reached output.

Verification
REQ-042 Load: start, then 64 bytes 0x00..0x3F with in_valid gaps -> dm[i]=i, 64 writes exactly, one core_req.
REQ-043 Readback: core_done low 10 cycles then high; dm[64..95]=0xA0+i; out_ready randomly stalled -> 32 bytes 0xA0..0xBF in order, one seq_done.
REQ-044 Stale done: core_done held high through START; drop it 3 cycles, then raise it -> RD_FETCH only after the drop.
REQ-045 Timeout: core_done held 0 -> err=1 and state ERR after 4095 RUN cycles; next start clears err and enters LOAD.
REQ-046 Reset: assert reset during byte 20 of LOAD -> outputs 0 immediately; start ignored while busy; a new start after release loads from address 0.
